// File: rtl/i_multibuf_controller_pkg.sv
// Shared definitions for the multi-buffer line input path.
// Contents:
//   buf_state_t : ownership state of one line buffer (FREE / FILLING / FULL).
//                 The readout controller uses the same encoding.
//   clog2       : ceiling log2, usable in parameter expressions.
package i_multibuf_controller_pkg;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/i_multibuf_controller_packer.sv
// Pixel-to-word packer. Pixels are packed little-endian: the first pixel of a
// word lands in bits [PIX_W-1:0].
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   i_clear       : drop any partially packed word
//   i_pix_valid   : i_pix is taken this cycle
//   i_pix         : pixel data
//   i_flush       : emit the partial word (zero-padded in its high pixels)
//   o_word        : word to be written (combinational, registered by the caller)
//   o_word_valid  : o_word is complete this cycle (full word or flush)
//   o_pix_cnt     : pixels currently held in the partial word
module i_multibuf_controller_packer
    import i_multibuf_controller_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 32,
    localparam int PPW   = WORD_W / PIX_W,
    localparam int CNT_W = clog2(PPW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_pix_valid,
    input  logic [PIX_W-1:0]  i_pix,
    input  logic              i_flush,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic [CNT_W-1:0]  o_pix_cnt
);

    logic [WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] w_merged;
    logic              w_last;

    // The accumulator is cleared whenever a word leaves, so unfilled high
    // pixels of a flushed word are already zero.
    assign w_merged     = r_acc | (WORD_W'(i_pix) << (PIX_W * int'(r_cnt)));
    assign w_last       = (r_cnt == CNT_W'(PPW - 1));
    assign o_word_valid = i_pix_valid ? w_last : (i_flush && (r_cnt != '0));
    assign o_word       = i_pix_valid ? w_merged : r_acc;
    assign o_pix_cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_pix_valid) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_flush) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/i_multibuf_controller.sv
// Multi-buffer line input controller. Packs a DVI-style pixel stream into
// WORD_W-bit words and writes each line into one of N_BUFS line buffers that
// share a RAM (buffer b occupies words b*STRIDE .. b*STRIDE+STRIDE-1).
// Ports:
//   pclk, reset          : pixel clock, synchronous active-high reset
//   vsync, hsync, vde    : video timing (hsync unused)
//   i_data               : pixel data, taken each cycle vde=1
//   rel_valid, rel_idx   : consumer returns a FULL buffer to FREE
//   we, addr, o_data     : RAM write port
//   line_valid/line_buf/line_words/line_trunc : line-complete event
//   frame_valid/frame_lines                   : frame-start event with line count
//   overflow             : sticky, a line was dropped for lack of a FREE buffer
module i_multibuf_controller
    import i_multibuf_controller_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int WORD_W       = 32,
    parameter int MAX_LINE_PIX = 2048,
    parameter int N_BUFS       = 2,
    parameter int ADDR_W       = 32,
    localparam int BIDX_W      = clog2(N_BUFS),
    localparam int LW_W        = clog2(MAX_LINE_PIX / (WORD_W / PIX_W)) + 1
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              hsync,
    input  logic              vde,
    input  logic [PIX_W-1:0]  i_data,
    input  logic              rel_valid,
    input  logic [BIDX_W-1:0] rel_idx,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] o_data,
    output logic              line_valid,
    output logic [BIDX_W-1:0] line_buf,
    output logic [LW_W-1:0]   line_words,
    output logic              line_trunc,
    output logic              frame_valid,
    output logic [15:0]       frame_lines,
    output logic              overflow
);

    localparam int PPW    = WORD_W / PIX_W;
    localparam int STRIDE = MAX_LINE_PIX / PPW;
    localparam int SW     = clog2(STRIDE);
    localparam int PC_W   = clog2(MAX_LINE_PIX) + 1;
    localparam int CNT_W  = clog2(PPW + 1);

    logic              r_vde_d;
    logic              r_vsync_d;
    buf_state_t        r_state [N_BUFS];
    logic [BIDX_W-1:0] r_rr;
    logic [BIDX_W-1:0] r_fill_idx;
    logic              r_filling;
    logic [PC_W-1:0]   r_pix_cnt;
    logic [LW_W-1:0]   r_word_idx;
    logic              r_trunc;
    logic [15:0]       r_line_cnt;

    logic              w_line_start;
    logic              w_line_end;
    logic              w_frame_start;
    logic              w_abort;
    logic              w_line_done;
    logic              w_found;
    logic [BIDX_W-1:0] w_alloc;
    logic              w_start_ok;
    logic              w_active;
    logic [BIDX_W-1:0] w_cur_idx;
    logic [PC_W-1:0]   w_cur_pix;
    logic [LW_W-1:0]   w_cur_word;
    logic              w_room;
    logic              w_pix_take;
    logic              w_pix_over;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic [CNT_W-1:0]  w_pend;
    buf_state_t        w_state_rel  [N_BUFS];
    buf_state_t        w_state_next [N_BUFS];

    // hsync is kept only so the receiver can connect unchanged.
    logic w_unused_hsync;
    assign w_unused_hsync = hsync;

    assign w_line_start  = vde & ~r_vde_d;
    assign w_line_end    = ~vde & r_vde_d;
    assign w_frame_start = vsync & ~r_vsync_d;
    // A frame start while filling kills the line: no flush, no event, not counted.
    assign w_abort       = w_frame_start & r_filling;
    assign w_line_done   = w_line_end & r_filling & ~w_abort;

    // Releases are applied before the allocator looks at the buffers, so a
    // buffer released in the line-start cycle can be taken immediately.
    always_comb begin
        for (int b = 0; b < N_BUFS; b++) begin
            w_state_rel[b] = r_state[b];
            if (rel_valid && int'(rel_idx) == b && r_state[b] == BUF_FULL)
                w_state_rel[b] = BUF_FREE;
        end
    end

    // Round-robin search for a FREE buffer starting at r_rr.
    always_comb begin
        w_found = 1'b0;
        w_alloc = '0;
        for (int i = 0; i < N_BUFS; i++) begin
            int j;
            j = int'(r_rr) + i;
            if (j >= N_BUFS)
                j = j - N_BUFS;
            if (!w_found && w_state_rel[j] == BUF_FREE) begin
                w_found = 1'b1;
                w_alloc = BIDX_W'(j);
            end
        end
    end

    assign w_start_ok = w_line_start & w_found;
    assign w_active   = (r_filling & ~w_abort) | w_start_ok;

    // In the line-start cycle the per-line counters are not yet loaded, so
    // the fresh allocation and zero counts are used directly.
    assign w_cur_idx  = w_start_ok ? w_alloc : r_fill_idx;
    assign w_cur_pix  = w_start_ok ? '0 : r_pix_cnt;
    assign w_cur_word = w_start_ok ? '0 : r_word_idx;
    assign w_room     = (w_cur_pix < PC_W'(MAX_LINE_PIX));
    assign w_pix_take = vde & w_active & w_room;
    assign w_pix_over = vde & w_active & ~w_room;
    assign w_addr     = (ADDR_W'(w_cur_idx) << SW) | ADDR_W'(w_cur_word);

    always_comb begin
        for (int b = 0; b < N_BUFS; b++) begin
            w_state_next[b] = w_state_rel[b];
            if (w_abort && int'(r_fill_idx) == b)
                w_state_next[b] = BUF_FREE;
            if (w_line_done && int'(r_fill_idx) == b)
                w_state_next[b] = BUF_FULL;
            if (w_start_ok && int'(w_alloc) == b)
                w_state_next[b] = BUF_FILLING;
        end
    end

    i_multibuf_controller_packer #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clk          (pclk),
        .rst          (reset),
        .i_clear      (w_abort),
        .i_pix_valid  (w_pix_take),
        .i_pix        (i_data),
        .i_flush      (w_line_done),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_pix_cnt    (w_pend)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_vde_d     <= 1'b0;
            r_vsync_d   <= 1'b0;
            for (int b = 0; b < N_BUFS; b++)
                r_state[b] <= BUF_FREE;
            r_rr        <= '0;
            r_fill_idx  <= '0;
            r_filling   <= 1'b0;
            r_pix_cnt   <= '0;
            r_word_idx  <= '0;
            r_trunc     <= 1'b0;
            r_line_cnt  <= '0;
            we          <= 1'b0;
            addr        <= '0;
            o_data      <= '0;
            line_valid  <= 1'b0;
            line_buf    <= '0;
            line_words  <= '0;
            line_trunc  <= 1'b0;
            frame_valid <= 1'b0;
            frame_lines <= '0;
            overflow    <= 1'b0;
        end else begin
            r_vde_d   <= vde;
            r_vsync_d <= vsync;
            for (int b = 0; b < N_BUFS; b++)
                r_state[b] <= w_state_next[b];

            we <= w_word_valid;
            if (w_word_valid) begin
                addr   <= w_addr;
                o_data <= w_word;
            end

            // The partial word (if any) is written in the same cycle as line_valid.
            line_valid <= w_line_done;
            if (w_line_done) begin
                line_buf   <= r_fill_idx;
                line_words <= r_word_idx + LW_W'(w_pend != '0);
                line_trunc <= r_trunc;
            end

            if (w_start_ok) begin
                r_filling  <= 1'b1;
                r_fill_idx <= w_alloc;
                r_rr       <= (int'(w_alloc) == N_BUFS - 1) ? '0 : w_alloc + BIDX_W'(1);
            end else if (w_abort || w_line_done) begin
                r_filling  <= 1'b0;
            end

            if (w_line_start && !w_found)
                overflow <= 1'b1;

            if (w_active) begin
                r_pix_cnt  <= w_cur_pix + PC_W'(w_pix_take);
                r_word_idx <= w_cur_word + LW_W'(w_word_valid);
                r_trunc    <= (r_trunc & ~w_start_ok) | w_pix_over;
            end

            if (w_frame_start)
                r_line_cnt <= '0;
            else if (w_line_done && r_line_cnt != 16'hFFFF)
                r_line_cnt <= r_line_cnt + 16'd1;

            frame_valid <= w_frame_start && (r_line_cnt != '0);
            if (w_frame_start && (r_line_cnt != '0))
                frame_lines <= r_line_cnt;
        end
    end

endmodule

// File: tb/tb_i_multibuf_controller.sv
// Directed bench for i_multibuf_controller (PIX_W=8, WORD_W=32,
// MAX_LINE_PIX=16, N_BUFS=2). Expected writes, line events and frame events
// are queued when stimulus is driven and compared when the DUT emits them.
module tb_i_multibuf_controller;

    localparam int MAXP = 16;

    logic        pclk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        hsync;
    logic        vde;
    logic [7:0]  i_data;
    logic        rel_valid;
    logic [0:0]  rel_idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] o_data;
    logic        line_valid;
    logic [0:0]  line_buf;
    logic [2:0]  line_words;
    logic        line_trunc;
    logic        frame_valid;
    logic [15:0] frame_lines;
    logic        overflow;

    always #5 pclk = ~pclk;

    i_multibuf_controller #(
        .PIX_W        (8),
        .WORD_W       (32),
        .MAX_LINE_PIX (MAXP),
        .N_BUFS       (2),
        .ADDR_W       (32)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vsync       (vsync),
        .hsync       (hsync),
        .vde         (vde),
        .i_data      (i_data),
        .rel_valid   (rel_valid),
        .rel_idx     (rel_idx),
        .we          (we),
        .addr        (addr),
        .o_data      (o_data),
        .line_valid  (line_valid),
        .line_buf    (line_buf),
        .line_words  (line_words),
        .line_trunc  (line_trunc),
        .frame_valid (frame_valid),
        .frame_lines (frame_lines),
        .overflow    (overflow)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [0:0] b;
        logic [2:0] w;
        logic       t;
    } ln_t;

    wr_t         wq[$];
    ln_t         lq[$];
    logic [15:0] fq[$];
    int checks = 0;
    int errors = 0;
    int lines  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every DUT event must match the head of its queue.
    always @(negedge pclk) begin
        if (we) begin
            chk("we_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", 64'(addr), 64'(e.a));
                chk("wr_data", 64'(o_data), 64'(e.d));
            end
        end
        if (line_valid) begin
            chk("line_expected", 64'(lq.size() != 0), 64'd1);
            if (lq.size() != 0) begin
                ln_t l;
                l = lq.pop_front();
                chk("line_buf", 64'(line_buf), 64'(l.b));
                chk("line_words", 64'(line_words), 64'(l.w));
                chk("line_trunc", 64'(line_trunc), 64'(l.t));
            end
        end
        if (frame_valid) begin
            chk("frame_expected", 64'(fq.size() != 0), 64'd1);
            if (fq.size() != 0) begin
                logic [15:0] f;
                f = fq.pop_front();
                chk("frame_lines", 64'(frame_lines), 64'(f));
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic frame_event();
        if (lines > 0) fq.push_back(16'(lines));
        lines = 0;
    endtask

    task automatic vsync_rise();
        frame_event();
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic release_buf(input int k);
        rel_valid = 1'b1;
        rel_idx   = 1'(k);
        tick();
        rel_valid = 1'b0;
        tick();
    endtask

    // exp_buf < 0: line must be dropped. rel_at >= 0: release that buffer in
    // the line-start cycle. abort_at >= 0: vsync rises at that pixel.
    task automatic send_line(input int npix, input int first, input int exp_buf,
                             input int rel_at, input int abort_at);
        int nt;
        int nw;
        logic [31:0] w;
        if (exp_buf >= 0) begin
            nt = (npix > MAXP) ? MAXP : npix;
            if (abort_at >= 0) nt = abort_at;
            nw = (abort_at >= 0) ? nt / 4 : (nt + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                w = '0;
                for (int p = 0; p < 4; p++)
                    if (k * 4 + p < nt) w[p*8 +: 8] = 8'(first + k * 4 + p);
                wq.push_back('{a: 32'(exp_buf * 4 + k), d: w});
            end
            if (abort_at < 0) begin
                lq.push_back('{b: 1'(exp_buf), w: 3'(nw), t: (npix > MAXP)});
                lines++;
            end
        end
        for (int i = 0; i < npix; i++) begin
            vde    = 1'b1;
            i_data = 8'(first + i);
            if (i == 0 && rel_at >= 0) begin
                rel_valid = 1'b1;
                rel_idx   = 1'(rel_at);
            end
            if (i == abort_at) begin
                frame_event();
                vsync = 1'b1;
            end
            tick();
            rel_valid = 1'b0;
        end
        vde = 1'b0;
        repeat (3) tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        vsync     = 1'b0;
        hsync     = 1'b0;
        vde       = 1'b0;
        i_data    = '0;
        rel_valid = 1'b0;
        rel_idx   = '0;
        repeat (3) tick();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_line_valid", 64'(line_valid), 64'd0);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Aligned line into buffer 0, then a partial-word line into buffer 1.
        send_line(8, 8'h01, 0, -1, -1);
        send_line(6, 8'h01, 1, -1, -1);
        chk("overflow_clear", 64'(overflow), 64'd0);

        // Both buffers FULL: third line dropped.
        send_line(4, 8'h40, -1, -1, -1);
        chk("overflow_set", 64'(overflow), 64'd1);
        release_buf(0);
        send_line(4, 8'h10, 0, -1, -1);

        // Release coinciding with line start makes buffer 0 available.
        send_line(5, 8'h30, 0, 0, -1);

        // Over-long line is truncated to MAXP pixels.
        release_buf(0);
        send_line(20, 8'h60, 0, -1, -1);
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Frame counting: 5 lines delivered so far, then a 3-line frame.
        vsync_rise();
        release_buf(0);
        release_buf(1);
        send_line(3, 8'h70, 1, -1, -1);
        send_line(4, 8'h80, 0, -1, -1);
        release_buf(1);
        send_line(7, 8'h90, 1, -1, -1);
        vsync_rise();

        // vsync mid-line aborts the line and frees its buffer.
        release_buf(0);
        release_buf(1);
        send_line(10, 8'hA0, 0, -1, 6);
        send_line(4, 8'hB0, 1, -1, -1);
        send_line(4, 8'hC0, 0, -1, -1);
        vsync_rise();

        // Reset mid-line abandons the line and frees every buffer.
        release_buf(0);
        vde = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'hF0 + i);
            tick();
        end
        vde   = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_line_valid", 64'(line_valid), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        lines = 0;
        repeat (2) tick();
        send_line(8, 8'hD0, 0, -1, -1);
        send_line(8, 8'hE0, 1, -1, -1);
        vsync_rise();

        repeat (6) tick();
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("lq_empty", 64'(lq.size()), 64'd0);
        chk("fq_empty", 64'(fq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
